// File: rtl/seq_sub_16.sv
// Slice-serial subtractor: DIFF = A - B - Bin, one SLICE per clock, LSB first.
// Start/busy/done handshake; results hold until the next accepted start.
module seq_sub_16 #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             Bout,
  output logic             V
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             carry_q, carry_n;
  logic [WIDTH-1:0] a_q, a_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [WIDTH-1:0] diff_q, diff_n;
  logic             bout_q, bout_n;
  logic             v_q, v_n;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   sum;
  logic             last;

  // Subtraction as A + ~B with the borrow folded into the carry chain
  assign a_sl = a_q[cnt_q*SLICE +: SLICE];
  assign b_sl = b_q[cnt_q*SLICE +: SLICE];
  assign sum  = {1'b0, a_sl} + {1'b0, ~b_sl}
              + {{SLICE{1'b0}}, carry_q};
  assign last = (cnt_q == CW'(NSL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      carry_q <= carry_n;
      a_q     <= a_n;
      b_q     <= b_n;
      diff_q  <= diff_n;
      bout_q  <= bout_n;
      v_q     <= v_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    carry_n = carry_q;
    a_n     = a_q;
    b_n     = b_q;
    diff_n  = diff_q;
    bout_n  = bout_q;
    v_n     = v_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_n     = A;
          b_n     = B;
          carry_n = ~Bin;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        diff_n[cnt_q*SLICE +: SLICE] = sum[SLICE-1:0];
        carry_n = sum[SLICE];
        cnt_n   = cnt_q + CW'(1);
        if (last) begin
          bout_n  = ~sum[SLICE];
          v_n     = (a_q[WIDTH-1] != b_q[WIDTH-1])
                 && (diff_n[WIDTH-1] != a_q[WIDTH-1]);
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign DIFF = diff_q;
  assign Bout = bout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_seq_sub_16.sv
// Scoreboard bench for seq_sub_16: arithmetic reference model,
// cycle-level occupancy model, monitor compares on every falling edge.
module tb_seq_sub_16;

  localparam int W   = 16;
  localparam int NSL = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] DIFF;
  logic         Bout;
  logic         V;

  seq_sub_16 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .DIFF (DIFF),
    .Bout (Bout),
    .V    (V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         v;
  } exp_t;

  exp_t q[$];
  exp_t last_res;
  int   busy_cnt = 0;
  int   checks = 0;
  int   fails = 0;
  int   dones = 0;

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic bin);
    exp_t e;
    int   ua, ub, sa, sb, r;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    r  = sa - sb - int'(bin);
    e.d  = W'(ua - ub - int'(bin));
    e.bo = (ua < ub + int'(bin));
    e.v  = (r > 32767) || (r < -32768);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Occupancy model: accepted start keeps the unit busy NSL+1 cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt = 0;
      q.delete();
      last_res = '{d: '0, bo: 1'b0, v: 1'b0};
    end else if (busy_cnt == 0) begin
      if (start) begin
        q.push_back(model(A, B, Bin));
        busy_cnt = NSL + 1;
      end
    end else begin
      busy_cnt--;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, busy_cnt != 0);
      check("done", done, busy_cnt == 1);
      if (done) begin
        dones++;
        if (q.size() == 0) begin
          check("done_without_request", 1, 0);
        end else begin
          last_res = q.pop_front();
          check("DIFF", DIFF, last_res.d);
          check("Bout", Bout, last_res.bo);
          check("V", V, last_res.v);
        end
      end else if (busy_cnt == 0) begin
        check("DIFF_hold", DIFF, last_res.d);
        check("Bout_hold", Bout, last_res.bo);
        check("V_hold", V, last_res.v);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_cnt != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy_cnt != 0) check("timeout", 1, 0);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin);
    @(negedge clk);
    A = a;
    B = b;
    Bin = bin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_DIFF", DIFF, 0);
    rst_n = 1'b1;
    @(negedge clk);

    d0 = dones;
    do_op(16'd12345, 16'd5432, 1'b0);
    check("first_done_count", dones - d0, 1);
    do_op(16'd0, 16'd1, 1'b0);
    do_op(16'd30000, 16'd30000, 1'b1);
    do_op(16'h8000, 16'd1, 1'b0);
    do_op(16'h7FFF, 16'hFFFF, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1);
    do_op(16'hFFFF, 16'h0000, 1'b0);

    // start and operand changes during RUN are ignored
    d0 = dones;
    @(negedge clk);
    A = 16'd20000;
    B = 16'd10000;
    Bin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'd1;
    B = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'd777;
    B = 16'd3;
    wait_idle();
    @(negedge clk);
    check("ignored_start_dones", dones - d0, 1);
    check("ignored_start_DIFF", DIFF, 10000);

    // asynchronous reset mid-operation
    d0 = dones;
    @(negedge clk);
    A = 16'd20000;
    B = 16'd10000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_DIFF", DIFF, 0);
    check("arst_Bout", Bout, 0);
    check("arst_V", V, 0);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("arst_no_done", dones - d0, 0);
    do_op(16'd5, 16'd3, 1'b0);
    check("post_rst_DIFF", DIFF, 2);

    // start held high: one accept every NSL+2 cycles
    d0 = dones;
    @(negedge clk);
    A = 16'd100;
    B = 16'd40;
    Bin = 1'b0;
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    check("held_start_dones", dones - d0, 4);

    // random traffic, including starts while busy
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      A = W'($urandom);
      B = W'($urandom);
      Bin = 1'($urandom);
      if ($urandom_range(0, 7) == 0) A = 16'h8000;
      if ($urandom_range(0, 7) == 0) B = 16'h7FFF;
    end
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
